// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the positions of the status flags within the packed flag register.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } serial_state_t;

    localparam int FLAG_BORROW_BIT = 0;
    localparam int FLAG_OVF_BIT    = 1;
    localparam int FLAG_W          = 2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    output logic d,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, with start/busy/done handshake.
// diff is the result shift register itself; borrow/ovf update only when the last bit completes.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    serial_state_t      r_state;
    serial_state_t      w_state_next;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bin;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [FLAG_W-1:0]  r_flags;
    logic               w_d;
    logic               w_bout;
    logic               w_accept;
    logic               w_last;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CNT_LAST);

    full_subtractor u_fs (
        .d    (w_d),
        .bout (w_bout),
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = start ? ST_SHIFT : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Operand MSBs are captured at accept because the operand registers shift away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_bin   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_flags <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_bin   <= 1'b0;
            r_a_msb <= a[N-1];
            r_b_msb <= b[N-1];
        end else if (r_state == ST_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[N-1:1]};
            r_bin <= w_bout;
            if (w_last) begin
                r_flags[FLAG_BORROW_BIT] <= w_bout;
                r_flags[FLAG_OVF_BIT]    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign diff   = r_res;
    assign borrow = r_flags[FLAG_BORROW_BIT];
    assign ovf    = r_flags[FLAG_OVF_BIT];

endmodule
